// File: rtl/bcd_pair_counter.sv
// ----------------------------------------------------------------------------
// bcd_pair_counter
//
// Two-digit BCD counter (00..99) that drives the seven-segment display stage.
// The count advances on an internal prescaler tick (when en=1) and/or on a
// rising edge of the manual step input. Direction comes from up. A
// synchronous load has priority over counting and clamps each nibble to 9.
//
// Parameters
//   TICK_DIV  prescaler period in clk cycles between automatic counts (>= 2)
//
// Ports
//   clk       system clock, rising edge active
//   arst      asynchronous reset, active low
//   en        enables the prescaler and automatic counting
//   up        1 = increment, 0 = decrement (tick and step events)
//   load      synchronous load of load_val (wins over count events)
//   load_val  {tens, ones} BCD value to load; nibbles > 9 load as 9
//   step      manual count request, one count per rising edge of step
//   dig1      tens digit (registered)
//   dig0      ones digit (registered)
//   upd       one-cycle pulse when dig1/dig0 first show a new value
//   wrap      one-cycle pulse on 99->00 (up) or 00->99 (down) count
//
// All outputs come straight from flops; there is no input-to-output
// combinational path.
// ----------------------------------------------------------------------------
module bcd_pair_counter #(
    parameter int TICK_DIV = 100
) (
    input  logic       clk,
    input  logic       arst,
    input  logic       en,
    input  logic       up,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       step,
    output logic [3:0] dig1,
    output logic [3:0] dig0,
    output logic       upd,
    output logic       wrap
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [PW-1:0] presc_q, presc_d;
    logic          step_q,  step_d;
    logic [3:0]    tens_q,  tens_d;
    logic [3:0]    ones_q,  ones_d;
    logic          upd_q,   upd_d;
    logic          wrap_q,  wrap_d;

    // ------------------------------------------------------------------------
    // Event detection
    // ------------------------------------------------------------------------
    logic tick;
    logic step_edge;
    logic count_ev;

    assign tick      = en && (presc_q == PRESC_LAST);
    assign step_edge = step & ~step_q;
    // A coincident tick and step edge collapse into one count; load discards
    // both.
    assign count_ev  = (tick | step_edge) & ~load;

    // ------------------------------------------------------------------------
    // Load value with per-nibble clamp to 9
    // ------------------------------------------------------------------------
    logic [3:0] ld_tens;
    logic [3:0] ld_ones;

    assign ld_tens = (load_val[7:4] > 4'd9) ? 4'd9 : load_val[7:4];
    assign ld_ones = (load_val[3:0] > 4'd9) ? 4'd9 : load_val[3:0];

    // ------------------------------------------------------------------------
    // BCD increment / decrement of the current value
    // ------------------------------------------------------------------------
    logic [3:0] cnt_tens;
    logic [3:0] cnt_ones;
    logic       cnt_wrap;

    always_comb begin
        cnt_tens = tens_q;
        cnt_ones = ones_q;
        cnt_wrap = 1'b0;
        if (up) begin
            if (ones_q >= 4'd9) begin
                cnt_ones = 4'd0;
                if (tens_q >= 4'd9) begin
                    cnt_tens = 4'd0;
                    cnt_wrap = 1'b1;
                end else begin
                    cnt_tens = tens_q + 4'd1;
                end
            end else begin
                cnt_ones = ones_q + 4'd1;
            end
        end else begin
            if (ones_q == 4'd0) begin
                cnt_ones = 4'd9;
                if (tens_q == 4'd0) begin
                    cnt_tens = 4'd9;
                    cnt_wrap = 1'b1;
                end else begin
                    cnt_tens = tens_q - 4'd1;
                end
            end else begin
                cnt_ones = ones_q - 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------------
    always_comb begin
        presc_d = presc_q;
        step_d  = step;          // step history follows step even during load
        tens_d  = tens_q;
        ones_d  = ones_q;
        upd_d   = 1'b0;
        wrap_d  = 1'b0;

        // Prescaler: cleared by load so the next tick lands TICK_DIV edges
        // later; held (not restarted) while en=0.
        if (load) begin
            presc_d = '0;
        end else if (en) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end

        if (load) begin
            tens_d = ld_tens;
            ones_d = ld_ones;
            upd_d  = (ld_tens != tens_q) || (ld_ones != ones_q);
        end else if (count_ev) begin
            // A count on a two-digit modulus-100 value always changes it.
            tens_d = cnt_tens;
            ones_d = cnt_ones;
            upd_d  = 1'b1;
            wrap_d = cnt_wrap;
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            presc_q <= '0;
            step_q  <= 1'b0;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
            upd_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            step_q  <= step_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            upd_q   <= upd_d;
            wrap_q  <= wrap_d;
        end
    end

    assign dig1 = tens_q;
    assign dig0 = ones_q;
    assign upd  = upd_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_bcd_pair_counter.sv
module tb_bcd_pair_counter;

    localparam int TICK_DIV = 4;

    logic       clk = 1'b0;
    logic       arst;
    logic       en;
    logic       up;
    logic       load;
    logic [7:0] load_val;
    logic       step;
    logic [3:0] dig1;
    logic [3:0] dig0;
    logic       upd;
    logic       wrap;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] val;
        logic       upd;
        logic       wrap;
        string      tag;
    } exp_t;

    exp_t sb[$];

    bcd_pair_counter #(.TICK_DIV(TICK_DIV)) dut (
        .clk      (clk),
        .arst     (arst),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .step     (step),
        .dig1     (dig1),
        .dig0     (dig0),
        .upd      (upd),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare DUT outputs against one popped scoreboard entry.
    task automatic cmp_entry(input exp_t e);
        chk({e.tag, ".dig"},  {dig1, dig0}, e.val);
        chk({e.tag, ".upd"},  {7'd0, upd},  {7'd0, e.upd});
        chk({e.tag, ".wrap"}, {7'd0, wrap}, {7'd0, e.wrap});
    endtask

    // Push the expectation for the coming edge, clock once, then pop and
    // compare #1 after the edge.
    task automatic edge_chk(input logic [7:0] v, input logic u, input logic w, input string tag);
        exp_t e;
        e.val = v; e.upd = u; e.wrap = w; e.tag = tag;
        sb.push_back(e);
        @(posedge clk); #1;
        if (sb.size() == 0) begin
            checks++; errors++;
            $error("FAIL %s: observed empty scoreboard expected one entry", tag);
        end else begin
            cmp_entry(sb.pop_front());
        end
    endtask

    initial begin
        arst = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 8'h00; step = 1'b0;

        // Reset state
        #2;
        cmp_entry('{8'h00, 1'b0, 1'b0, "reset"});
        @(posedge clk); @(posedge clk); #1;
        cmp_entry('{8'h00, 1'b0, 1'b0, "reset_held"});

        // Auto count from reset release
        arst = 1'b1; en = 1'b1; up = 1'b1;
        for (int n = 1; n <= 3; n++) begin
            for (int k = 0; k < TICK_DIV - 1; k++)
                edge_chk(8'(n - 1), 1'b0, 1'b0, "auto_hold");
            edge_chk(8'(n), 1'b1, 1'b0, "auto_tick");
        end

        // Up wrap with manual steps
        en = 1'b0; load = 1'b1; load_val = 8'h98;
        edge_chk(8'h98, 1'b1, 1'b0, "ld98");
        load = 1'b0;
        step = 1'b1; edge_chk(8'h99, 1'b1, 1'b0, "up_99");
        step = 1'b0; edge_chk(8'h99, 1'b0, 1'b0, "up_99_hold");
        step = 1'b1; edge_chk(8'h00, 1'b1, 1'b1, "up_wrap");
        step = 1'b0; edge_chk(8'h00, 1'b0, 1'b0, "up_wrap_hold");
        step = 1'b1; edge_chk(8'h01, 1'b1, 1'b0, "up_01");
        step = 1'b0; edge_chk(8'h01, 1'b0, 1'b0, "up_01_hold");

        // Down borrow and wrap
        up = 1'b0; load = 1'b1; load_val = 8'h10;
        edge_chk(8'h10, 1'b1, 1'b0, "ld10");
        load = 1'b0;
        step = 1'b1; edge_chk(8'h09, 1'b1, 1'b0, "dn_borrow");
        step = 1'b0; edge_chk(8'h09, 1'b0, 1'b0, "dn_hold");
        step = 1'b1; edge_chk(8'h08, 1'b1, 1'b0, "dn_08");
        step = 1'b0; edge_chk(8'h08, 1'b0, 1'b0, "dn_hold2");
        load = 1'b1; load_val = 8'h00;
        edge_chk(8'h00, 1'b1, 1'b0, "ld00");
        load = 1'b0;
        step = 1'b1; edge_chk(8'h99, 1'b1, 1'b1, "dn_wrap");
        step = 1'b0; edge_chk(8'h99, 1'b0, 1'b0, "dn_wrap_hold");

        // Step coincident with tick counts once
        up = 1'b1; load = 1'b1; load_val = 8'h20;
        edge_chk(8'h20, 1'b1, 1'b0, "ld20");
        load = 1'b0; en = 1'b1;
        for (int k = 0; k < TICK_DIV - 1; k++)
            edge_chk(8'h20, 1'b0, 1'b0, "coin_hold");
        step = 1'b1; edge_chk(8'h21, 1'b1, 1'b0, "coin_once");
        step = 1'b0; edge_chk(8'h21, 1'b0, 1'b0, "coin_after");

        // Step with load: load wins, prescaler restarts
        step = 1'b1; load = 1'b1; load_val = 8'h42;
        edge_chk(8'h42, 1'b1, 1'b0, "ld42_step");
        load = 1'b0;  // step stays high: already recorded, no count
        for (int k = 0; k < TICK_DIV - 1; k++)
            edge_chk(8'h42, 1'b0, 1'b0, "ld42_hold");
        edge_chk(8'h43, 1'b1, 1'b0, "ld42_tick");
        step = 1'b0; en = 1'b0;
        edge_chk(8'h43, 1'b0, 1'b0, "en_off");

        // Clamp, identical load, held step
        load = 1'b1; load_val = 8'hFA;
        edge_chk(8'h99, 1'b1, 1'b0, "clampFA");
        load_val = 8'h99;
        edge_chk(8'h99, 1'b0, 1'b0, "ld_same");
        load_val = 8'h3C;
        edge_chk(8'h39, 1'b1, 1'b0, "clamp3C");
        load_val = 8'h55;
        edge_chk(8'h55, 1'b1, 1'b0, "ld55");
        load = 1'b0; step = 1'b1;
        edge_chk(8'h56, 1'b1, 1'b0, "held_first");
        for (int k = 0; k < 9; k++)
            edge_chk(8'h56, 1'b0, 1'b0, "held_rest");
        step = 1'b0;

        // Asynchronous reset mid-count
        en = 1'b1; load = 1'b1; load_val = 8'h57;
        edge_chk(8'h57, 1'b1, 1'b0, "ld57");
        load = 1'b0;
        #2 arst = 1'b0;
        #1;
        cmp_entry('{8'h00, 1'b0, 1'b0, "async_rst"});
        @(posedge clk); #1;
        arst = 1'b1;
        for (int k = 0; k < TICK_DIV - 1; k++)
            edge_chk(8'h00, 1'b0, 1'b0, "post_rst_hold");
        edge_chk(8'h01, 1'b1, 1'b0, "post_rst_tick");

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL sb_drain: observed %0d entries expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
